// File: rtl/dec_issue_ctrl.sv
// Issue controller: FIFO-buffers fetched words, issues them to the decoder and
// sequences flush / sleep / trap. Optional issue counter under DEC_ISSUE_PERF_EN.
module dec_issue_ctrl #(
  parameter int DEPTH       = 4,
  parameter int TRAP_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_instr_i,
  output logic        fetch_ready_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_valid_o,
  input  logic        dec_ready_i,
  input  logic        irq_i,
  output logic        flush_o,
  output logic        sleep_o,
  output logic        exc_o,
  output logic [1:0]  exc_cause_o,
  output logic [15:0] issue_count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] TRAP_LOAD = 4'(TRAP_CYCLES - 1);

  localparam logic [31:0] WFI_W    = 32'h10500073;
  localparam logic [31:0] ECALL_W  = 32'h00000073;
  localparam logic [31:0] EBREAK_W = 32'h00100073;
  localparam logic [31:0] MRET_W   = 32'h30200073;
  localparam logic [31:0] DRET_W   = 32'h7B200073;

  typedef enum logic [1:0] {RUN, FLUSH, SLEEP, TRAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]  trap_cnt_q, trap_cnt_d;
  logic        exc_q, exc_set;
  logic [1:0]  cause_q, cause_d;
  logic        clear, empty, full, push, issue;
  logic [31:0] head;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_redirect(input logic [31:0] w);
    is_redirect = (w[6:0] == 7'h63) || (w[6:0] == 7'h67) || (w[6:0] == 7'h6F) ||
                  (w == MRET_W) || (w == DRET_W);
  endfunction

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign fetch_ready_o = !full && (state_q == RUN);
  assign instr_valid_o = !empty && (state_q == RUN);
  assign instr_rdata_o = instr_valid_o ? head : 32'h0;
  assign push          = fetch_valid_i && fetch_ready_o;
  assign issue         = instr_valid_o && dec_ready_i;

  assign flush_o     = (state_q == FLUSH);
  assign sleep_o     = (state_q == SLEEP);
  assign exc_o       = exc_q;
  assign exc_cause_o = cause_q;

  // Next-state: control-flow decisions are taken on the word being issued
  always_comb begin
    state_d    = state_q;
    trap_cnt_d = trap_cnt_q;
    cause_d    = cause_q;
    exc_set    = 1'b0;
    clear      = 1'b0;
    case (state_q)
      RUN: begin
        if (issue) begin
          if (is_redirect(head)) begin
            state_d = FLUSH;
            clear   = 1'b1;
          end else if (head == WFI_W) begin
            state_d = SLEEP;
          end else if (head == ECALL_W || head == EBREAK_W || !is_legal(head[6:0])) begin
            state_d    = TRAP;
            clear      = 1'b1;
            exc_set    = 1'b1;
            trap_cnt_d = TRAP_LOAD;
            cause_d    = (head == ECALL_W)  ? 2'd1 :
                         (head == EBREAK_W) ? 2'd2 : 2'd0;
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
        clear   = 1'b1;
      end
      SLEEP: begin
        if (irq_i) state_d = RUN;
      end
      TRAP: begin
        if (trap_cnt_q == 4'd0) state_d = RUN;
        else                    trap_cnt_d = trap_cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // Control registers: state, pointers, trap counter, exception pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      trap_cnt_q <= 4'd0;
      exc_q      <= 1'b0;
      cause_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      trap_cnt_q <= trap_cnt_d;
      exc_q      <= exc_set;
      cause_q    <= cause_d;
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
        if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= fetch_instr_i;
  end

`ifdef DEC_ISSUE_PERF_EN
  logic [15:0] issue_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    issue_cnt_q <= 16'h0;
    else if (issue) issue_cnt_q <= issue_cnt_q + 16'h1;
  end
  assign issue_count_o = issue_cnt_q;
`else
  assign issue_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_dec_issue_ctrl.sv
// Bench for dec_issue_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model of the issue controller.
module tb_dec_issue_ctrl;

  localparam int DEPTH       = 4;
  localparam int TRAP_CYCLES = 3;
  localparam int M_RUN = 0, M_FLUSH = 1, M_SLEEP = 2, M_TRAP = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_valid_i;
  logic [31:0] fetch_instr_i;
  logic        fetch_ready_o;
  logic [31:0] instr_rdata_o;
  logic        instr_valid_o;
  logic        dec_ready_i;
  logic        irq_i;
  logic        flush_o, sleep_o, exc_o;
  logic [1:0]  exc_cause_o;
  logic [15:0] issue_count_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_q [$];
  int          m_mode;
  int          m_trap_left;
  logic        m_exc;
  logic [1:0]  m_cause;
  logic [15:0] m_cnt;

  dec_issue_ctrl #(.DEPTH(DEPTH), .TRAP_CYCLES(TRAP_CYCLES)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i),
    .fetch_ready_o(fetch_ready_o), .instr_rdata_o(instr_rdata_o),
    .instr_valid_o(instr_valid_o), .dec_ready_i(dec_ready_i),
    .irq_i(irq_i), .flush_o(flush_o), .sleep_o(sleep_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o), .issue_count_o(issue_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                      7'h63, 7'h67, 7'h6F, 7'h73};
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef DEC_ISSUE_PERF_EN
    return m_cnt;
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode = M_RUN; m_trap_left = 0; m_exc = 1'b0; m_cause = 2'd0; m_cnt = 16'h0;
  endtask

  task automatic check_outputs();
    bit rdy, vld;
    rdy = (m_mode == M_RUN) && (m_q.size() < DEPTH);
    vld = (m_mode == M_RUN) && (m_q.size() > 0);
    check("fetch_ready", 32'(fetch_ready_o), 32'(rdy));
    check("instr_valid", 32'(instr_valid_o), 32'(vld));
    check("instr_rdata", instr_rdata_o, vld ? m_q[0] : 32'h0);
    check("flush", 32'(flush_o), 32'(m_mode == M_FLUSH));
    check("sleep", 32'(sleep_o), 32'(m_mode == M_SLEEP));
    check("exc", 32'(exc_o), 32'(m_exc));
    check("exc_cause", 32'(exc_cause_o), 32'(m_cause));
    check("issue_count", 32'(issue_count_o), 32'(exp_count()));
  endtask

  // Advance the model across one rising edge given the inputs applied before it
  task automatic model_update(input logic fv, input logic [31:0] w, input logic dr, input logic ir);
    bit push, issue;
    logic [31:0] h;
    push  = fv && (m_mode == M_RUN) && (m_q.size() < DEPTH);
    issue = dr && (m_mode == M_RUN) && (m_q.size() > 0);
    m_exc = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (issue) begin
          h = m_q.pop_front();
          m_cnt++;
          if (h[6:0] inside {7'h63, 7'h67, 7'h6F} || h == 32'h30200073 || h == 32'h7B200073) begin
            m_mode = M_FLUSH; m_q.delete(); push = 0;
          end else if (h == 32'h10500073) begin
            m_mode = M_SLEEP;
          end else if (h == 32'h00000073 || h == 32'h00100073 || !op_legal(h[6:0])) begin
            m_mode = M_TRAP; m_q.delete(); push = 0;
            m_trap_left = TRAP_CYCLES; m_exc = 1'b1;
            m_cause = (h == 32'h00000073) ? 2'd1 : (h == 32'h00100073) ? 2'd2 : 2'd0;
          end
        end
        if (push) m_q.push_back(w);
      end
      M_FLUSH: m_mode = M_RUN;
      M_SLEEP: if (ir) m_mode = M_RUN;
      default: begin
        m_trap_left--;
        if (m_trap_left == 0) m_mode = M_RUN;
      end
    endcase
  endtask

  task automatic step(input logic fv, input logic [31:0] w, input logic dr, input logic ir);
    @(negedge clk_i);
    check_outputs();
    fetch_valid_i = fv; fetch_instr_i = w; dec_ready_i = dr; irq_i = ir;
    @(posedge clk_i);
    model_update(fv, w, dr, ir);
  endtask

  task automatic check_reset_values();
    check("rst_ready", 32'(fetch_ready_o), 32'd1);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_rdata", instr_rdata_o, 32'h0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_sleep", 32'(sleep_o), 32'd0);
    check("rst_exc", 32'(exc_o), 32'd0);
    check("rst_cause", 32'(exc_cause_o), 32'd0);
    check("rst_count", 32'(issue_count_o), 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 15))
      0, 1, 2, 3, 4, 5: return {r[31:7], 7'h13};
      6:  return {r[31:7], 7'h33};
      7:  return {r[31:7], 7'h03};
      8:  return 32'h0D90006F;
      9:  return {r[31:7], 7'h63};
      10: return {r[31:7], 7'h67};
      11: return r[0] ? 32'h10500073 : (r[1] ? 32'h30200073 : 32'h7B200073);
      12: return r[0] ? 32'h00000073 : 32'h00100073;
      13: return 32'h0FFFFFFF;
      14: return 32'h30002573;
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] ITYPE = 32'hE000C113;

  initial begin
    rst_ni = 1'b0; fetch_valid_i = 0; fetch_instr_i = 0; dec_ready_i = 0; irq_i = 0;
    model_reset();
    #12;
    check_reset_values();
    rst_ni = 1'b1;

    // Back-to-back issue of plain ALU words
    for (int i = 0; i < 4; i++) step(1, ITYPE, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
`ifdef DEC_ISSUE_PERF_EN
    check("count_after_4", 32'(issue_count_o), 32'd4);
`endif

    // Back-pressure: fifth push refused, then in-order drain
    for (int i = 0; i < 5; i++) step(1, ITYPE + (i << 20), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);

    // JAL with two words queued behind it
    step(1, 32'h0D90006F, 0, 0);
    step(1, ITYPE, 0, 0);
    step(1, ITYPE + 32'h100000, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // WFI, idle asleep, single-cycle irq pulse, then drain held words
    step(1, 32'h10500073, 0, 0);
    step(1, ITYPE, 0, 0);
    step(1, ITYPE + 32'h200000, 0, 0);
    step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    // Illegal opcode then ECALL, each followed by a full trap window
    step(1, 32'h0FFFFFFF, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(1, 32'h00000073, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);

    // Asynchronous reset in the middle of SLEEP with words held
    for (int i = 0; i < 4; i++) step(1, (i == 0) ? 32'h10500073 : ITYPE, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("sleep_before_rst", 32'(m_mode), 32'(M_SLEEP));
    #2 rst_ni = 1'b0;
    #1 check_reset_values();
    model_reset();
    #1 rst_ni = 1'b1;
    step(0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0);
    step(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
